event_decoder: RTL and testbench
================================

Name: event_decoder

Overview:
- Receive end of the event-report stream: consumes 256-bit AXI-Stream event messages (byte 0 = message type, byte 1 = event code) and turns each into a one-cycle event strobe, a sticky pending bit, a per-event saturating counter and a level interrupt.
- Sits on the host or monitor side of the event-report link and feeds control/status registers and the interrupt controller.

Parameters:
- MSG_TYPE, 2, required value of byte 0 for a message to be valid.
- EVENT_TYPES, 3, number of event codes; valid codes are 1..EVENT_TYPES; code k maps to bit k-1.
- COUNTER_WIDTH, 16, width of each event counter and of the bad-message counter.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- AXIS_IN_TDATA  in  256  message beat; [7:0] = type, [15:8] = code, bits [255:16] are ignored.
- AXIS_IN_TVALID  in  1  beat valid.
- AXIS_IN_TREADY  out  1  registered ready.
- freeze  in  1  when high, TREADY drops on the next cycle (backpressure).
- evt_strobe  out  EVENT_TYPES  one-cycle pulse per decoded event.
- pending  out  EVENT_TYPES  sticky per-event flags.
- pending_clear  in  EVENT_TYPES  per-bit clear, sampled every cycle.
- irq_enable  in  EVENT_TYPES  per-bit interrupt mask.
- irq  out  1  registered level interrupt.
- count_clear  in  1  synchronous clear of all counters.
- evt_count  out  EVENT_TYPES*COUNTER_WIDTH  concatenated counters; event k-1 at [(k-1)*COUNTER_WIDTH +: COUNTER_WIDTH].
- bad_msg_count  out  COUNTER_WIDTH  count of rejected messages.
- last_code  out  8  code of the most recent valid message.

Behaviour:
- Reset (resetn low, asynchronous) forces every output and internal register to 0: TREADY, evt_strobe, pending, irq, evt_count, bad_msg_count, last_code, and pipeline valids. A message in flight when reset asserts is discarded.
- TREADY register: reset value 0. Loads ~freeze on every clk edge. Consequences:
  - After reset release, the first possible accept is at the 2nd edge.
  - freeze takes effect one cycle late.
- Accept condition: a beat is accepted at an edge where TVALID & TREADY are both high. No other condition gates acceptance; a valid beat held while TREADY is low waits. Every accepted beat is one message.
- Stage 1, at the accept edge N: capture type and code, set s1_valid. s1_valid clears on any edge without an accept.
- Stage 2, at edge N+1, when s1_valid:
  - Message is valid when type == MSG_TYPE and 1 <= code <= EVENT_TYPES.
  - If valid:
    - evt_strobe[code-1] = 1 for exactly one cycle; all other strobes are 0.
    - pending[code-1] set.
    - evt_count[code-1] increments, saturating at all-ones.
    - last_code = code.
  - If invalid: bad_msg_count increments, saturating. No strobe, no pending change, no last_code change.
- Throughput: one message per cycle sustained; back-to-back beats each produce their own strobe on consecutive cycles.
- Latency: accept edge N -> strobe, counter and pending visible after edge N+1 -> irq visible after edge N+2.
- pending: bit b clears at an edge where pending_clear[b] = 1. If set and clear hit the same bit at the same edge, set wins.
- irq: registered; at each edge irq <= |(pending & irq_enable). It deasserts one cycle after the last enabled pending bit clears.
- count_clear: zeroes all evt_count and bad_msg_count. If an increment coincides with count_clear, the affected counter becomes 1, not 0; that event is not lost.
- Saturation: a counter at 2^COUNTER_WIDTH-1 stays there until count_clear.
- Reset mid-stream: all state returns to 0 immediately. TREADY stays low until the 1st edge after release.

Test Plan:
- Reset release, freeze=0, TVALID held with type=2, code=1: TREADY rises at edge 1, accept at edge 2. Then evt_strobe=3'b001 for exactly 1 cycle, pending=001, evt_count[0]=1, last_code=1; with irq_enable=001, irq=1 one cycle after pending sets.
- Back-to-back codes 1, 2, 3, 2 on consecutive cycles: strobes 001, 010, 100, 010 on consecutive cycles; counts 1/2/1; pending=111.
- Invalid messages type=3 code=1, type=2 code=0, type=2 code=4: bad_msg_count=3, no strobes, pending unchanged, last_code unchanged.
- pending_clear=010 asserted in the same cycle a code-2 message reaches stage 2: pending[1] stays 1. A clear on the next cycle gives pending[1]=0, and irq drops one cycle later.
- Preload counter 0 to 0xFFFF and send code 1: it stays 0xFFFF. Assert count_clear coincident with a code-1 increment: evt_count[0]=1, other counters 0.
- freeze pulsed high for 3 cycles during a TVALID stream: TREADY low for exactly 3 cycles, delayed by one. No beat is lost or duplicated; the strobe count equals the number of beats sent.

Source files
------------

// File: rtl/event_decoder.sv
// rtl/event_decoder.sv - event-report stream decoder: strobes, sticky pending, saturating counters, irq
// Two-stage pipeline: stage 1 captures the accepted beat, stage 2 decodes and updates all state.
module event_decoder #(
  parameter int unsigned MSG_TYPE      = 2,
  parameter int unsigned EVENT_TYPES   = 3,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [255:0]                         AXIS_IN_TDATA,
  input  logic                                 AXIS_IN_TVALID,
  output logic                                 AXIS_IN_TREADY,
  input  logic                                 freeze,
  output logic [EVENT_TYPES-1:0]               evt_strobe,
  output logic [EVENT_TYPES-1:0]               pending,
  input  logic [EVENT_TYPES-1:0]               pending_clear,
  input  logic [EVENT_TYPES-1:0]               irq_enable,
  output logic                                 irq,
  input  logic                                 count_clear,
  output logic [EVENT_TYPES*COUNTER_WIDTH-1:0] evt_count,
  output logic [COUNTER_WIDTH-1:0]             bad_msg_count,
  output logic [7:0]                           last_code
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic                     r_tready;
  logic                     r_s1_valid;
  logic [7:0]               r_s1_type;
  logic [7:0]               r_s1_code;
  logic [EVENT_TYPES-1:0]   r_strobe;
  logic [EVENT_TYPES-1:0]   r_pending;
  logic                     r_irq;
  logic [COUNTER_WIDTH-1:0] r_cnt [EVENT_TYPES];
  logic [COUNTER_WIDTH-1:0] r_bad;
  logic [7:0]               r_last_code;

  logic                     w_accept;
  logic                     w_good;
  logic                     w_bad;
  logic [EVENT_TYPES-1:0]   w_set;
  logic                     w_unused_tdata;

  assign w_unused_tdata = ^AXIS_IN_TDATA[255:16];
  assign w_accept       = AXIS_IN_TVALID & r_tready;

  assign w_good = r_s1_valid
                  && (r_s1_type == 8'(MSG_TYPE))
                  && (r_s1_code >= 8'd1)
                  && (r_s1_code <= 8'(EVENT_TYPES));
  assign w_bad  = r_s1_valid & ~w_good;

  always_comb begin
    w_set = '0;
    for (int k = 0; k < int'(EVENT_TYPES); k++) begin
      if (w_good && (r_s1_code == 8'(k + 1))) begin
        w_set[k] = 1'b1;
      end
    end
  end

  // An increment coinciding with a clear lands as 1 so the event is not lost.
  function automatic logic [COUNTER_WIDTH-1:0] f_cnt_next(
    input logic [COUNTER_WIDTH-1:0] cnt,
    input logic                     inc,
    input logic                     clr
  );
    if (clr) begin
      return inc ? COUNTER_WIDTH'(1) : '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      return cnt + COUNTER_WIDTH'(1);
    end
    return cnt;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tready    <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_type   <= '0;
      r_s1_code   <= '0;
      r_strobe    <= '0;
      r_pending   <= '0;
      r_irq       <= 1'b0;
      r_bad       <= '0;
      r_last_code <= '0;
      for (int k = 0; k < int'(EVENT_TYPES); k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_tready   <= ~freeze;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_type <= AXIS_IN_TDATA[7:0];
        r_s1_code <= AXIS_IN_TDATA[15:8];
      end
      r_strobe  <= w_set;
      // Set wins over a same-cycle clear.
      r_pending <= (r_pending & ~pending_clear) | w_set;
      r_irq     <= |(r_pending & irq_enable);
      if (w_good) begin
        r_last_code <= r_s1_code;
      end
      r_bad <= f_cnt_next(r_bad, w_bad, count_clear);
      for (int k = 0; k < int'(EVENT_TYPES); k++) begin
        r_cnt[k] <= f_cnt_next(r_cnt[k], w_set[k], count_clear);
      end
    end
  end

  for (genvar g = 0; g < int'(EVENT_TYPES); g++) begin : g_cnt_out
    assign evt_count[g*COUNTER_WIDTH +: COUNTER_WIDTH] = r_cnt[g];
  end

  assign AXIS_IN_TREADY = r_tready;
  assign evt_strobe     = r_strobe;
  assign pending        = r_pending;
  assign irq            = r_irq;
  assign bad_msg_count  = r_bad;
  assign last_code      = r_last_code;

endmodule

// File: tb/tb_event_decoder.sv
// tb/tb_event_decoder.sv - randomized and directed bench for event_decoder against a message-level model
// Narrow counters keep the saturation case short.
module tb_event_decoder;

  localparam int MT   = 2;
  localparam int ET   = 3;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             resetn;
  logic [255:0]     tdata;
  logic             tvalid;
  logic             tready;
  logic             freeze;
  logic [ET-1:0]    evt_strobe;
  logic [ET-1:0]    pending;
  logic [ET-1:0]    pending_clear;
  logic [ET-1:0]    irq_enable;
  logic             irq;
  logic             count_clear;
  logic [ET*CW-1:0] evt_count;
  logic [CW-1:0]    bad_msg_count;
  logic [7:0]       last_code;

  always #5 clk = ~clk;

  event_decoder #(.MSG_TYPE(MT), .EVENT_TYPES(ET), .COUNTER_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TREADY(tready),
    .freeze(freeze), .evt_strobe(evt_strobe), .pending(pending),
    .pending_clear(pending_clear), .irq_enable(irq_enable), .irq(irq),
    .count_clear(count_clear), .evt_count(evt_count),
    .bad_msg_count(bad_msg_count), .last_code(last_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the outputs should show after the latest edge.
  int m_tready, m_strobe, m_pending, m_irq, m_last, m_bad;
  int m_cnt [ET];
  int m_have, m_type, m_code;
  int n_accepted, n_strobes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_next(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc) return (c >= MAXC) ? MAXC : c + 1;
    return c;
  endfunction

  task automatic model_reset();
    m_tready = 0; m_strobe = 0; m_pending = 0; m_irq = 0; m_last = 0; m_bad = 0;
    m_have = 0; m_type = 0; m_code = 0;
    for (int k = 0; k < ET; k++) m_cnt[k] = 0;
  endtask

  // Message accepted at one edge is decoded at the next; irq follows pending by one edge.
  task automatic model_edge();
    int set_mask;
    int pend_old;
    bit good;
    bit bad;
    if (!resetn) begin
      model_reset();
      return;
    end
    set_mask = 0; good = 0; bad = 0;
    pend_old = m_pending;
    m_irq = ((pend_old & int'(irq_enable)) != 0) ? 1 : 0;
    if (m_have != 0) begin
      good = (m_type == MT) && (m_code >= 1) && (m_code <= ET);
      bad  = !good;
      if (good) set_mask = 1 << (m_code - 1);
    end
    m_strobe  = set_mask;
    m_pending = ((pend_old & ~int'(pending_clear)) | set_mask) & ((1 << ET) - 1);
    for (int k = 0; k < ET; k++) m_cnt[k] = sat_next(m_cnt[k], ((set_mask >> k) & 1) != 0, count_clear);
    m_bad = sat_next(m_bad, bad, count_clear);
    if (good) m_last = m_code;
    m_have = (tvalid && m_tready != 0) ? 1 : 0;
    if (m_have != 0) begin
      m_type = int'(tdata[7:0]);
      m_code = int'(tdata[15:8]);
      n_accepted++;
    end
    m_tready = freeze ? 0 : 1;
  endtask

  task automatic compare_all();
    chk("tready", 32'(tready), 32'(m_tready));
    chk("strobe", 32'(evt_strobe), 32'(m_strobe));
    chk("pending", 32'(pending), 32'(m_pending));
    chk("irq", 32'(irq), 32'(m_irq));
    for (int k = 0; k < ET; k++) chk($sformatf("cnt%0d", k), 32'(evt_count[k*CW +: CW]), 32'(m_cnt[k]));
    chk("bad", 32'(bad_msg_count), 32'(m_bad));
    chk("last_code", 32'(last_code), 32'(m_last));
    n_strobes += $countones(evt_strobe);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_beat(input int typ, input int code);
    for (int i = 0; i < 8; i++) tdata[i*32 +: 32] = $urandom();
    tdata[7:0]  = 8'(typ);
    tdata[15:8] = 8'(code);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  int q_strobe [$];
  int base_strobes, base_acc, low_cnt;

  initial begin
    resetn = 1'b0; tvalid = 1'b0; freeze = 1'b0; pending_clear = '0;
    irq_enable = '0; count_clear = 1'b0; tdata = '0;
    n_accepted = 0; n_strobes = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step();

    // Release with a valid code-1 beat already waiting.
    resetn = 1'b1; tvalid = 1'b1; irq_enable = 3'b001; set_beat(MT, 1);
    step();
    chk("t1_tready_edge1", 32'(tready), 32'd1);
    step();
    tvalid = 1'b0;
    chk("t1_no_strobe_at_accept", 32'(evt_strobe), 32'd0);
    step();
    chk("t1_strobe", 32'(evt_strobe), 32'b001);
    chk("t1_cnt0", 32'(evt_count[CW-1:0]), 32'd1);
    chk("t1_last", 32'(last_code), 32'd1);
    chk("t1_irq_not_yet", 32'(irq), 32'd0);
    step();
    chk("t1_strobe_one_cycle", 32'(evt_strobe), 32'd0);
    chk("t1_irq", 32'(irq), 32'd1);

    // Back-to-back codes.
    count_clear = 1'b1; step(); count_clear = 1'b0;
    q_strobe.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        tvalid = 1'b1;
        set_beat(MT, (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : 2);
      end else begin
        tvalid = 1'b0;
      end
      step();
      q_strobe.push_back(int'(evt_strobe));
    end
    chk("b2b_s1", 32'(q_strobe[1]), 32'b001);
    chk("b2b_s2", 32'(q_strobe[2]), 32'b010);
    chk("b2b_s3", 32'(q_strobe[3]), 32'b100);
    chk("b2b_s4", 32'(q_strobe[4]), 32'b010);
    chk("b2b_counts", 32'(evt_count), 32'({8'd1, 8'd2, 8'd1}));
    chk("b2b_pending", 32'(pending), 32'b111);

    // Invalid messages.
    count_clear = 1'b1; step(); count_clear = 1'b0;
    base_strobes = n_strobes;
    tvalid = 1'b1; set_beat(3, 1); step();
    set_beat(MT, 0); step();
    set_beat(MT, 4); step();
    idle(2);
    chk("inv_bad", 32'(bad_msg_count), 32'd3);
    chk("inv_pending", 32'(pending), 32'b111);
    chk("inv_last", 32'(last_code), 32'd2);
    chk("inv_no_strobes", 32'(n_strobes - base_strobes), 32'd0);

    // Pending set wins over a coincident clear.
    pending_clear = 3'b111; step(); pending_clear = '0;
    irq_enable = 3'b010; idle(2);
    tvalid = 1'b1; set_beat(MT, 2); step();
    tvalid = 1'b0; pending_clear = 3'b010; step();
    chk("pc_set_wins", 32'(pending[1]), 32'd1);
    step();
    chk("pc_cleared", 32'(pending[1]), 32'd0);
    chk("pc_irq_held", 32'(irq), 32'd1);
    pending_clear = '0; step();
    chk("pc_irq_drop", 32'(irq), 32'd0);

    // Saturation and clear coincident with an increment.
    count_clear = 1'b1; step(); count_clear = 1'b0;
    tvalid = 1'b1; set_beat(MT, 1);
    for (int i = 0; i < MAXC + 3; i++) step();
    idle(2);
    chk("sat_hold", 32'(evt_count[CW-1:0]), 32'(MAXC));
    tvalid = 1'b1; set_beat(MT, 1); step();
    tvalid = 1'b0; count_clear = 1'b1; step(); count_clear = 1'b0;
    chk("clr_inc_cnt0", 32'(evt_count[CW-1:0]), 32'd1);
    chk("clr_inc_others", 32'(evt_count[ET*CW-1:CW]), 32'd0);

    // Freeze pulse during a stream.
    base_strobes = n_strobes; base_acc = n_accepted; low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tvalid = 1'b1; set_beat(MT, $urandom_range(1, ET));
      freeze = (i >= 3 && i <= 5);
      step();
      if (!tready) low_cnt++;
    end
    freeze = 1'b0;
    idle(2);
    chk("frz_low_cycles", 32'(low_cnt), 32'd3);
    chk("frz_accepts", 32'(n_accepted - base_acc), 32'd7);
    chk("frz_strobes", 32'(n_strobes - base_strobes), 32'd7);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tvalid = ($urandom_range(0, 3) != 0);
      set_beat(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : MT, $urandom_range(0, ET + 1));
      freeze = ($urandom_range(0, 9) == 0);
      pending_clear = ($urandom_range(0, 3) == 0) ? ET'($urandom_range(0, 7)) : '0;
      count_clear = ($urandom_range(0, 199) == 0);
      if (c % 64 == 0) irq_enable = ET'($urandom_range(0, 7));
      step();
    end
    freeze = 1'b0; pending_clear = '0; count_clear = 1'b0;

    // Asynchronous reset mid-stream.
    tvalid = 1'b1; set_beat(MT, 3); step(); step();
    #2 resetn = 1'b0;
    #1 model_reset();
    compare_all();
    chk("rst_tready_low", 32'(tready), 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("rst_tready_back", 32'(tready), 32'd1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
